// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared constants and FSM state type for the register file write arbiter
// Purpose: default sizing of the arbiter, the write counter width and the
//          two-state FSM encoding shared by the arbiter top and its picker.
// Contents: DEF_NUM_REQ, DEF_ADDR_W, DEF_DATA_W, CNT_W, state_t (IDLE, WRITE).
package regfile_write_arbiter_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_DATA_W  = 32;
    localparam int CNT_W       = 16;

    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t WRITE = 1'b1;

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// rtl/regfile_write_arbiter_rr_pick.sv - round-robin priority picker
// Purpose: returns the first set bit of eligible, searching upward from
//          rr_ptr and wrapping at NUM_REQ.
// Ports:
//   eligible  in   NUM_REQ  candidate requesters
//   rr_ptr    in   IDX_W    index with highest priority this cycle
//   winner    out  IDX_W    selected index (0 when valid is low)
//   valid     out  1        at least one candidate was eligible
module rr_pick
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    always_comb begin
        int                 idx;
        logic [IDX_W-1:0]   idx_sel;
        winner  = '0;
        valid   = 1'b0;
        idx     = 0;
        idx_sel = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx     = (int'(rr_ptr) + off) % NUM_REQ;
            idx_sel = IDX_W'(idx);
            if (!valid && eligible[idx_sel]) begin
                valid  = 1'b1;
                winner = idx_sel;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter funnelling requesters into one register file write port
// Purpose: each cycle picks one requester (round-robin, the requester being
//          acknowledged this cycle excluded), registers its address/data and
//          issues the write plus acknowledge in the following cycle.
// Option:  RF_ARB_ZERO_PROTECT_EN - grants to address 0 are acknowledged but
//          no write strobe is issued and the write counter does not advance.
// Ports:
//   Clk         in   1                 clock, rising edge
//   Rst         in   1                 synchronous active-high reset
//   req_i       in   NUM_REQ           per-requester write request
//   addr_i      in   NUM_REQ*ADDR_W    packed addresses, requester k at [k*ADDR_W +: ADDR_W]
//   wdata_i     in   NUM_REQ*DATA_W    packed write data, same packing
//   ack_o       out  NUM_REQ           one-cycle acknowledge, one-hot or zero
//   WriteEn     out  1                 register file write strobe
//   WriteAddr   out  ADDR_W            register file write address
//   data_o      out  DATA_W            register file write data
//   busy_o      out  1                 any request pending or write in progress
//   wr_count_o  out  16                writes issued, wraps
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_i,
    output logic [NUM_REQ-1:0]        ack_o,
    output logic                      WriteEn,
    output logic [ADDR_W-1:0]         WriteAddr,
    output logic [DATA_W-1:0]         data_o,
    output logic                      busy_o,
    output logic [CNT_W-1:0]          wr_count_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   ptr_nxt;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   win_q;
    logic               win_valid;
    logic               allow_q;
    logic               wr_allow;
    logic [NUM_REQ-1:0] eligible;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_data;

    // The requester being acknowledged still has req_i high this cycle
    // (it only drops or renews on the closing edge), so it must not win again.
    assign eligible = req_i & ~ack_o;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .eligible (eligible),
        .rr_ptr   (rr_ptr),
        .winner   (win_idx),
        .valid    (win_valid)
    );

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == IDX_W'(k)) begin
                win_addr = addr_i[k*ADDR_W +: ADDR_W];
                win_data = wdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

`ifdef RF_ARB_ZERO_PROTECT_EN
    assign wr_allow = (win_addr != '0);
`else
    assign wr_allow = 1'b1;
`endif

    assign ptr_nxt   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
    assign state_nxt = win_valid ? WRITE : IDLE;

    always_comb begin
        ack_o = '0;
        if (state == WRITE) begin
            ack_o[win_q] = 1'b1;
        end
    end

    assign WriteEn = (state == WRITE) && allow_q;

    // A write strobe still showing in the reset cycle is being aborted, so it
    // does not keep busy_o up.
    assign busy_o = (|req_i) | (WriteEn & ~Rst);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            win_q      <= '0;
            allow_q    <= 1'b0;
            WriteAddr  <= '0;
            data_o     <= '0;
            wr_count_o <= '0;
        end else begin
            state <= state_nxt;
            if (win_valid) begin
                win_q     <= win_idx;
                allow_q   <= wr_allow;
                WriteAddr <= win_addr;
                data_o    <= win_data;
                rr_ptr    <= ptr_nxt;
            end
            if (WriteEn) begin
                wr_count_o <= wr_count_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

`ifdef RF_ARB_ZERO_PROTECT_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    localparam int M_NONE = 0;
    localparam int M_WALL = 1;
    localparam int M_CONT = 2;
    localparam int M_RAND = 3;
    localparam int M_FAIR = 4;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic [3:0]    req_i = '0;
    logic [19:0]   addr_i = '0;
    logic [127:0]  wdata_i = '0;
    logic [3:0]    ack_o;
    logic          WriteEn;
    logic [4:0]    WriteAddr;
    logic [31:0]   data_o;
    logic          busy_o;
    logic [15:0]   wr_count_o;

    regfile_write_arbiter dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .req_i      (req_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .ack_o      (ack_o),
        .WriteEn    (WriteEn),
        .WriteAddr  (WriteAddr),
        .data_o     (data_o),
        .busy_o     (busy_o),
        .wr_count_o (wr_count_o)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int mode   = M_NONE;
    int next_k = 0;

    // Requester side: one outstanding request per requester.
    bit          pend [4];
    logic [4:0]  a    [4];
    logic [31:0] d    [4];
    int          fair_left [4];

    // Reference model of what the write port shows in the current cycle.
    bit          m_wr;
    int          m_win;
    int          m_ptr;
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_cnt;
    int          total_writes;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        int idx = -1;
        int n = 0;
        for (int k = 0; k < 4; k++) begin
            if (v[k]) begin
                idx = k;
                n++;
            end
        end
        return (n > 1) ? -2 : idx;
    endfunction

    task automatic check_outputs();
        logic [3:0] exp_ack;
        exp_ack = m_wr ? (4'b0001 << m_win) : 4'b0000;
        check_eq("ack", 32'(ack_o), 32'(exp_ack));
        check_eq("we", 32'(WriteEn), 32'(m_we));
        check_eq("waddr", 32'(WriteAddr), 32'(m_addr));
        check_eq("wdata", data_o, m_data);
        check_eq("count", 32'(wr_count_o), 32'(m_cnt));
        check_eq("busy", 32'(busy_o), 32'((|req_i) | (m_we & !Rst)));
    endtask

    task automatic update_requesters();
        for (int k = 0; k < 4; k++) begin
            if (pend[k] && m_wr && m_win == k && !Rst) pend[k] = 1'b0;
        end
        case (mode)
            M_WALL: if (!pend[0] && next_k < 32) begin
                pend[0] = 1'b1;
                a[0] = 5'(next_k);
                d[0] = 32'(next_k);
                next_k++;
            end
            M_CONT: for (int k = 0; k < 4; k++) begin
                if (!pend[k]) begin
                    pend[k] = 1'b1;
                    a[k] = 5'($urandom_range(1, 31));
                    d[k] = $urandom;
                end
            end
            M_RAND: for (int k = 0; k < 4; k++) begin
                if (!pend[k] && $urandom_range(0, 1) == 1) begin
                    pend[k] = 1'b1;
                    a[k] = 5'($urandom_range(0, 31));
                    d[k] = $urandom;
                end
            end
            M_FAIR: for (int k = 1; k < 4; k += 2) begin
                if (!pend[k] && fair_left[k] > 0) begin
                    pend[k] = 1'b1;
                    a[k] = 5'($urandom_range(1, 31));
                    d[k] = $urandom;
                    fair_left[k]--;
                end
            end
            default: ;
        endcase
        for (int k = 0; k < 4; k++) begin
            req_i[k] = pend[k];
            addr_i[k*5 +: 5] = a[k];
            wdata_i[k*32 +: 32] = d[k];
        end
    endtask

    // Advances the model across the coming rising edge using the inputs the
    // bench has just applied.
    task automatic model_edge();
        int w;
        w = -1;
        if (Rst) begin
            m_wr = 0; m_we = 0; m_ptr = 0; m_addr = '0; m_data = '0; m_cnt = 0;
        end else begin
            if (m_we) begin
                m_cnt = (m_cnt + 1) % 65536;
                total_writes++;
            end
            for (int off = 0; off < 4; off++) begin
                int k;
                k = (m_ptr + off) % 4;
                if (w < 0 && pend[k] && !(m_wr && m_win == k)) w = k;
            end
            if (w >= 0) begin
                m_wr = 1; m_win = w; m_addr = a[w]; m_data = d[w];
                m_we = ZP ? (a[w] != 0) : 1'b1;
                m_ptr = (w + 1) % 4;
            end else begin
                m_wr = 0; m_we = 0;
            end
        end
    endtask

    task automatic step();
        check_outputs();
        update_requesters();
        model_edge();
        @(posedge Clk);
        @(negedge Clk);
        cyc++;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        mode = M_NONE;
        for (int k = 0; k < 4; k++) pend[k] = 1'b0;
        step();
        step();
        Rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int c;
        mode = M_NONE;
        c = 0;
        while (c < 50 && (m_wr || pend[0] || pend[1] || pend[2] || pend[3])) begin
            step();
            c++;
        end
        check_eq(tag, 32'(c < 50), 32'd1);
    endtask

    initial begin
        int last_ack, n_ack, c, g0, g1, w;
        bit done;
        for (int k = 0; k < 4; k++) begin
            pend[k] = 0; a[k] = '0; d[k] = '0; fair_left[k] = 0;
        end
        m_wr = 0; m_we = 0; m_ptr = 0; m_win = 0; m_addr = '0; m_data = '0; m_cnt = 0;
        total_writes = 0;
        @(negedge Clk);

        // Reset state
        do_reset();
        check_eq("rst_ack", 32'(ack_o), 32'd0);
        check_eq("rst_we", 32'(WriteEn), 32'd0);
        check_eq("rst_addr", 32'(WriteAddr), 32'd0);
        check_eq("rst_data", data_o, 32'd0);
        check_eq("rst_count", 32'(wr_count_o), 32'd0);

        // Write-all: requester 0 writes addr k / data k
        mode = M_WALL; next_k = 0; last_ack = -1; n_ack = 0; done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            if (ack_o[0]) begin
                if (last_ack >= 0) check_eq("wall_spacing", 32'(cyc - last_ack), 32'd2);
                check_eq("wall_addr", 32'(WriteAddr), 32'(n_ack));
                check_eq("wall_data", data_o, 32'(n_ack));
                last_ack = cyc;
                n_ack++;
            end
            done = (next_k == 32) && !pend[0] && !m_wr;
        end
        check_eq("wall_done", 32'(done), 32'd1);
        check_eq("wall_acks", 32'(n_ack), 32'd32);
        check_eq("wall_count", 32'(wr_count_o), ZP ? 32'd31 : 32'd32);

        // Full contention from reset
        Rst = 1'b1;
        for (int k = 0; k < 4; k++) pend[k] = 0;
        mode = M_CONT;
        step();
        step();
        Rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq("cont_grant", 32'(onehot_idx(ack_o)), 32'(i % 4));
            check_eq("cont_we", 32'(WriteEn), 32'd1);
        end
        drain("cont_drain");

        // Pointer fairness: grant to 1, then 4'b1010 -> 3, then 1
        do_reset();
        pend[1] = 1'b1; a[1] = 5'd9; d[1] = 32'h1111_0001;
        c = 0;
        while (c < 10 && !(m_wr && m_win == 1)) begin
            step();
            c++;
        end
        check_eq("fair_first", 32'(c < 10), 32'd1);
        fair_left[1] = 1; fair_left[3] = 1;
        mode = M_FAIR;
        g0 = -1; g1 = -1;
        for (int i = 0; i < 10 && g1 < 0; i++) begin
            step();
            w = onehot_idx(ack_o);
            if (w != -1) begin
                if (g0 < 0) g0 = w;
                else g1 = w;
            end
        end
        check_eq("fair_next", 32'(g0), 32'd3);
        check_eq("fair_then", 32'(g1), 32'd1);
        drain("fair_drain");

        // Reset asserted in the WRITE cycle of requester 2
        pend[2] = 1'b1; a[2] = 5'd7; d[2] = $urandom;
        c = 0;
        while (c < 10 && !(m_wr && m_win == 2)) begin
            step();
            c++;
        end
        check_eq("rmw_reach", 32'(c < 10), 32'd1);
        Rst = 1'b1;
        step();
        check_eq("rmw_ack", 32'(ack_o), 32'd0);
        check_eq("rmw_we", 32'(WriteEn), 32'd0);
        check_eq("rmw_addr", 32'(WriteAddr), 32'd0);
        check_eq("rmw_data", data_o, 32'd0);
        check_eq("rmw_count", 32'(wr_count_o), 32'd0);
        check_eq("rmw_busy", 32'(busy_o), 32'd1);
        Rst = 1'b0;
        step();
        check_eq("rmw_regrant", 32'(ack_o), 32'h4);
        drain("rmw_drain");

        // Random traffic
        do_reset();
        mode = M_RAND;
        repeat (400) step();
        drain("rand_drain");
        step();
        check_eq("idle_busy", 32'(busy_o), 32'd0);

        // Counter wrap after 65536 writes
        do_reset();
        mode = M_CONT;
        total_writes = 0;
        c = 0;
        while (c < 70000 && total_writes < 65536) begin
            step();
            c++;
        end
        check_eq("wrap_reached", 32'(total_writes), 32'd65536);
        check_eq("wrap_count", 32'(wr_count_o), 32'd0);
        check_eq("wrap_we", 32'(WriteEn), 32'd1);
        drain("wrap_drain");
        check_eq("wrap_final", 32'(wr_count_o), 32'(m_cnt));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  NUM_REQ, 4, number of write requesters (2..8)
  ADDR_W, 5, register address width
  DATA_W, 32, register data width
REQ-002 Ports SHALL be, one per line:
  Clk  input  1  single clock, all state on rising edge
  Rst  input  1  reset, synchronous, active-high
  req_i  input  NUM_REQ  per-requester write request
  addr_i  input  NUM_REQ*ADDR_W  packed target addresses, requester k at bits [k*ADDR_W +: ADDR_W]
  wdata_i  input  NUM_REQ*DATA_W  packed write data, same packing
  ack_o  output  NUM_REQ  one-cycle acknowledge, one-hot or zero
  WriteEn  output  1  register file write strobe
  WriteAddr  output  ADDR_W  register file write address
  data_o  output  DATA_W  register file write data
  busy_o  output  1  high while any req_i is high or WriteEn is high
  wr_count_o  output  16  number of writes issued to the register file

Function
REQ-003 Handshake: a requester SHALL hold req_i high with stable addr/data until it sees its ack_o bit high, and SHALL drop req_i or present a new request on the edge that ends the ack cycle.
REQ-004 Eligible set per cycle = req_i AND NOT ack_o (the requester acknowledged this cycle is masked).
REQ-005 Winner SHALL be the first eligible index searching upward, with wrap, from rr_ptr; rr_ptr SHALL update to winner+1 mod NUM_REQ on every grant and hold otherwise.
REQ-006 FSM states IDLE and WRITE: IDLE->WRITE when eligible set nonempty; WRITE->WRITE when eligible set nonempty; WRITE->IDLE otherwise.
REQ-007 In WRITE, WriteEn=1, WriteAddr/data_o carry the winner's registered addr/data, and ack_o[winner]=1, all in the same cycle (latency: request sampled in cycle N -> write and ack in cycle N+1).
REQ-008 In IDLE, WriteEn=0 and ack_o=0; WriteAddr and data_o SHALL hold their last values.
REQ-009 Throughput: one write per cycle under contention; a lone requester SHALL be granted every other cycle (masked by REQ-004).
REQ-010 wr_count_o SHALL increment by 1 on each WRITE cycle and wrap 16'hFFFF->0.
REQ-011 Out-of-range addresses cannot exist (ADDR_W bits); all ADDR_W codes SHALL be forwarded unchanged except as REQ-015 states.

Reset
REQ-012 Rst high at a rising edge SHALL force, from the next cycle: state IDLE, rr_ptr=0, WriteEn=0, ack_o=0, WriteAddr=0, data_o=0, wr_count_o=0.
REQ-013 Rst asserted during WRITE SHALL abort it: no ack for the aborted grant in the following cycle; requester keeps req_i high and is re-arbitrated after reset release.
REQ-014 busy_o during reset SHALL follow req_i only (WriteEn is 0).

Configuration
REQ-015 With RF_ARB_ZERO_PROTECT_EN defined, a grant to address 0 SHALL produce ack_o but WriteEn=0 and SHALL NOT increment wr_count_o; without it, address 0 writes SHALL be forwarded like any other.

Structure
REQ-016 A shared package SHALL hold the FSM state typedef (IDLE, WRITE), default NUM_REQ/ADDR_W/DATA_W constants and the counter width 16.
REQ-017 The round-robin priority picker SHALL be one sub-module, rr_pick (inputs eligible vector and rr_ptr; outputs winner index and valid).

Verification
REQ-018 Write-all: requester 0 writes addr k, data k for k=0..31 -> 32 acks spaced 2 cycles, WriteAddr/data_o = k, wr_count_o=32 (31 and no address-0 write with RF_ARB_ZERO_PROTECT_EN).
REQ-019 Full contention: all 4 req_i high from reset, held 8 cycles with re-requests -> grant order 0,1,2,3,0,1,2,3, WriteEn high 8 consecutive cycles.
REQ-020 Pointer fairness: req_i=4'b1010 after a grant to 1 -> next grant 3, then 1.
REQ-021 Reset mid-write: Rst pulsed in the WRITE cycle of requester 2 -> next cycle all outputs zero, wr_count_o=0; requester 2 granted 1 cycle after Rst drops.
REQ-022 Counter wrap: force 65536 writes -> wr_count_o returns to 0, no stall or glitch on WriteEn.
